enc83_req_encoder: RTL and testbench
====================================

# enc83_req_encoder

Sequential 8-to-3 request encoder, the encoding counterpart of the team's 3-to-8 decoder with active-low enable. It latches one-hot or multi-hot request lines into a sticky pending register, grants one request at a time as a 3-bit code with a valid/ack handshake, and clears each bit only when its grant is acknowledged. It sits between eight request sources and a single downstream consumer that drives a `decoder38_enable_low`-style select.

## Interface
Parameters: none. Widths are fixed at 8 requests and a 3-bit code.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `e`  in  1  — active-low enable.
  - 0: requests are sampled and new grants may start.
  - 1: requests are ignored and no new grant starts.
- `req`  in  8  — request lines, active-high, level-sampled every cycle.
- `ack`  in  1  — consumer accepts the current grant; ignored while `valid`=0.
- `w`  out  3  — granted request index. Registered; stable for the whole time `valid`=1.
- `valid`  out  1  — a grant is presented on `w`.
- `pending`  out  8  — sticky pending-request register.
- `multi`  out  1  — registered; 1 when `pending` has 2 or more bits set.

## Operation
- Pending update, every edge: `pending <= (pending & ~clr) | (e==0 ? req : 0)`.
  - `clr` is one-hot of `w` when `valid & ack`, else 0.
  - Set wins over clear: a bit requested in its own ack cycle stays pending.
- FSM with two states.
  - IDLE: `valid`=0. If `e`==0 and `pending`!=0, load `w` with the selected index and go to GRANT.
  - GRANT: `valid`=1 and `w` is held. On `ack`, clear the bit and return to IDLE. Without `ack`, stay in GRANT regardless of `e` or `req`; there is no abort.
- Selection is made on the registered `pending` value, never on raw `req`.
- Default selection is fixed priority: the highest set index wins (bit 7 highest).
- `multi` is recomputed from the next-state `pending` every edge.
- Reset values:
  - `pending`=0, `w`=0, `valid`=0, `multi`=0.
  - state=IDLE; round-robin pointer=0 (when compiled in).

## Timing
- Latency from a request to its grant:
  - `req` bit high at edge N (with `e`=0) → `pending` bit set after edge N.
  - `valid`=1 with `w` after edge N+1, provided the FSM is in IDLE.
- Handshake:
  - A grant completes on the edge where `valid`=1 and `ack`=1.
  - `valid` drops after that edge and stays low for exactly one cycle.
  - The next grant appears after the following edge if `pending`!=0 and `e`=0.
  - Peak throughput is one grant per 2 cycles.
- `ack` held high continuously: each grant lasts exactly 1 cycle, followed by a 1-cycle gap.
- `e` rising during GRANT: the current grant stays until acked; no new grant starts while `e`=1.
- `e`=1: `pending` is retained and only clears via ack.
- Same request bit set repeatedly: no counting; one pending bit means one grant.
- `rst_n` asserted mid-GRANT: `valid`, `w`, `pending` and `multi` go to reset values immediately (asynchronously), with no ack required.
- `rst_n` deassertion: the first sampling edge is the first rising `clk` after release.

## Configuration
- `ENC83_RR_EN` defined: round-robin selection.
  - Search descends from (`ptr`-1) mod 8, wrapping, so `ptr`=0 searches 7,6,…,0.
  - On each ack, `ptr` <= granted index.
  - No bit can starve while it stays pending.
- `ENC83_RR_EN` undefined: fixed highest-index priority.
  - No pointer register exists.
  - Lower bits can starve under continuous high-index requests.
- The first grant after reset is identical in both builds.

## Test plan
- Enable off: reset, then `e`=1 with `req`=8'hFF for 4 cycles → `pending`=0, `valid`=0 throughout, `w`=0.
- Single request: `e`=0 with a 1-cycle `req`=8'h01 at edge N → `pending`=8'h01 after N. `valid`=1 with `w`=0 after N+1. Ack → `pending`=0 and `valid`=0 next cycle; `multi`=0 throughout.
- Multi-hot burst: 1-cycle `req`=8'hA4, `ack` tied high → grants `w`=7, 5, 2 in that order, each `valid` pulse 1 cycle with a 1-cycle gap. `multi`=1 until the grant for 5 is acked, then 0.
- Fairness: `req`=8'h81 held, `ack` tied high.
  - Fixed priority → `w`=7 on every grant.
  - `ENC83_RR_EN` → `w`=7, 0, 7, 0, …
- Set-wins collision: `req` bit 3 asserted in the same cycle that `w`=3 is acked → bit 3 stays in `pending` and is granted again 2 edges later.
- Reset mid-grant: `rst_n` pulsed low while `valid`=1 with `w`=6 and `pending`=8'h41 → all outputs 0 immediately, with no dependence on `clk`. After release, no grant occurs until a new `req` arrives.

Source files
------------

// File: rtl/enc83_req_encoder_if.sv
// Request/grant bundle for the 8-to-3 request encoder.
// The request sources and the downstream consumer sit on the master side.
// The encoder itself sits on the slave side.
interface enc83_req_encoder_if;
    logic       e;
    logic [7:0] req;
    logic       ack;
    logic [2:0] w;
    logic       valid;
    logic [7:0] pending;
    logic       multi;

    modport master (
        output e,
        output req,
        output ack,
        input  w,
        input  valid,
        input  pending,
        input  multi
    );

    modport slave (
        input  e,
        input  req,
        input  ack,
        output w,
        output valid,
        output pending,
        output multi
    );
endinterface

// File: rtl/enc83_req_encoder.sv
// Sequential 8-to-3 request encoder with a sticky pending register.
// It grants one request at a time on w/valid, and each grant is retired by ack.
// `e` is an active-low enable that gates both request sampling and new grants.
// Compile-time option ENC83_RR_EN selects round-robin arbitration.
// Without ENC83_RR_EN, the highest set index always wins.
module enc83_req_encoder (
    input  logic               clk,
    input  logic               rst_n,
    enc83_req_encoder_if.slave bus
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0] state_q;
    logic [2:0] w_q;
    logic [7:0] pending_q;
    logic [7:0] pending_nx;
    logic [7:0] clr;
    logic       multi_q;
    logic       valid;
    logic [2:0] sel_idx;
    logic       sel_found;

    assign valid       = (state_q == ST_GRANT);
    assign bus.valid   = valid;
    assign bus.w       = w_q;
    assign bus.pending = pending_q;
    assign bus.multi   = multi_q;

    // Retire only the bit whose grant is being acknowledged on this edge.
    always_comb begin
        clr = 8'h00;
        if (valid && bus.ack) begin
            clr[w_q] = 1'b1;
        end
    end

    // Sets take precedence over the clear, so a bit re-requested in its own ack cycle stays pending.
    always_comb begin
        pending_nx = (pending_q & ~clr) | (bus.e ? 8'h00 : bus.req);
    end

`ifdef ENC83_RR_EN
    logic [2:0] ptr_q;
    logic [2:0] rr_idx;

    // Search downward from just below the last granted index and wrap around, so nothing starves.
    always_comb begin
        sel_idx   = 3'd0;
        sel_found = 1'b0;
        rr_idx    = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            rr_idx = ptr_q - 3'(k);
            if (!sel_found && pending_q[rr_idx]) begin
                sel_idx   = rr_idx;
                sel_found = 1'b1;
            end
        end
    end

    // The pointer remembers the last acknowledged grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 3'd0;
        end else if (valid && bus.ack) begin
            ptr_q <= w_q;
        end
    end
`else
    // Fixed priority: the highest set index wins, because later loop iterations overwrite earlier ones.
    always_comb begin
        sel_idx   = 3'd0;
        sel_found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (pending_q[i]) begin
                sel_idx   = 3'(i);
                sel_found = 1'b1;
            end
        end
    end
`endif

    // Pending register, plus the multi flag computed from the value pending takes after this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 8'h00;
            multi_q   <= 1'b0;
        end else begin
            pending_q <= pending_nx;
            multi_q   <= ((pending_nx & (pending_nx - 8'h01)) != 8'h00);
        end
    end

    // Two-state grant FSM: a grant is held until it is acknowledged and can never be aborted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            w_q     <= 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!bus.e && sel_found) begin
                        w_q     <= sel_idx;
                        state_q <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (bus.ack) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enc83_req_encoder.sv
// Self-checking bench for enc83_req_encoder.
// Expected grant indices are queued when the stimulus is applied.
// A monitor pops them as each grant completes its handshake.
// Define ENC83_RR_EN here as well as in the RTL to check the round-robin build.
module tb_enc83_req_encoder;

    logic clk;
    logic rst_n;

    enc83_req_encoder_if bus ();

    enc83_req_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int       error_count = 0;
    int       check_count = 0;
    int       exp_q[$];
    logic       prev_valid;
    logic       prev_ack;
    logic [2:0] prev_w;

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the bench ever stalls.
    initial begin
        #50000;
        $display("[TB] FAIL watchdog: got timeout, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h, want %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic e_val, input logic [7:0] req_val, input logic ack_val);
        bus.e   = e_val;
        bus.req = req_val;
        bus.ack = ack_val;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 8'h00, 1'b0);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checkOutput("drain", exp_q.size(), 0);
    endtask

    // The monitor compares each completed grant with the queue and checks that w holds while a grant waits.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_ack   = 1'b0;
            prev_w     = 3'd0;
        end else begin
            if (prev_valid && !prev_ack && bus.valid) begin
                checkOutput("w_hold", bus.w, prev_w);
            end
            if (bus.valid && bus.ack) begin
                checkOutput("grant_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    checkOutput("grant_w", bus.w, exp_q.pop_front());
                end
            end
            prev_valid = bus.valid;
            prev_ack   = bus.ack;
            prev_w     = bus.w;
        end
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b1, 8'h00, 1'b0);
        #2;
        checkOutput("rst_pending", bus.pending, 8'h00);
        checkOutput("rst_w", bus.w, 3'd0);
        checkOutput("rst_valid", bus.valid, 1'b0);
        checkOutput("rst_multi", bus.multi, 1'b0);
        #10;
        rst_n = 1'b1;

        // Enable off: requests are ignored.
        applyStimulus(1'b1, 8'hFF, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("en_off_pending", bus.pending, 8'h00);
            checkOutput("en_off_valid", bus.valid, 1'b0);
            checkOutput("en_off_w", bus.w, 3'd0);
        end

        // Single request, with the grant held for one extra cycle before the ack.
        applyStimulus(1'b0, 8'h01, 1'b0);
        tick();
        checkOutput("single_pending", bus.pending, 8'h01);
        checkOutput("single_valid_n", bus.valid, 1'b0);
        checkOutput("single_multi_n", bus.multi, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        exp_q.push_back(0);
        tick();
        checkOutput("single_valid_n1", bus.valid, 1'b1);
        checkOutput("single_w_n1", bus.w, 3'd0);
        checkOutput("single_multi_n1", bus.multi, 1'b0);
        tick();
        checkOutput("single_valid_hold", bus.valid, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        tick();
        checkOutput("single_pending_clr", bus.pending, 8'h00);
        checkOutput("single_valid_clr", bus.valid, 1'b0);
        checkOutput("single_multi_clr", bus.multi, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        waitDrain(5);
        doReset();

        // Multi-hot burst with ack held high.
        exp_q.push_back(7);
        exp_q.push_back(5);
        exp_q.push_back(2);
        applyStimulus(1'b0, 8'hA4, 1'b1);
        tick();
        checkOutput("burst_pending", bus.pending, 8'hA4);
        checkOutput("burst_multi0", bus.multi, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        tick();
        checkOutput("burst_valid1", bus.valid, 1'b1);
        tick();
        checkOutput("burst_gap1", bus.valid, 1'b0);
        checkOutput("burst_multi1", bus.multi, 1'b1);
        checkOutput("burst_pending1", bus.pending, 8'h24);
        tick();
        checkOutput("burst_valid2", bus.valid, 1'b1);
        tick();
        checkOutput("burst_gap2", bus.valid, 1'b0);
        checkOutput("burst_multi2", bus.multi, 1'b0);
        tick();
        checkOutput("burst_valid3", bus.valid, 1'b1);
        tick();
        checkOutput("burst_pending_end", bus.pending, 8'h00);
        waitDrain(5);
        applyStimulus(1'b0, 8'h00, 1'b0);
        doReset();

        // Fairness with bits 7 and 0 held continuously.
`ifdef ENC83_RR_EN
        exp_q.push_back(7);
        exp_q.push_back(0);
        exp_q.push_back(7);
        exp_q.push_back(0);
`else
        exp_q.push_back(7);
        exp_q.push_back(7);
        exp_q.push_back(7);
        exp_q.push_back(7);
`endif
        applyStimulus(1'b0, 8'h81, 1'b1);
        waitDrain(30);
        applyStimulus(1'b0, 8'h00, 1'b0);
        doReset();

        // Set wins over clear when bit 3 is re-requested in its own ack cycle.
        applyStimulus(1'b0, 8'h08, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0);
        exp_q.push_back(3);
        tick();
        checkOutput("coll_w", bus.w, 3'd3);
        applyStimulus(1'b0, 8'h08, 1'b1);
        exp_q.push_back(3);
        tick();
        checkOutput("coll_pending", bus.pending, 8'h08);
        checkOutput("coll_gap", bus.valid, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        tick();
        checkOutput("coll_regrant_valid", bus.valid, 1'b1);
        checkOutput("coll_regrant_w", bus.w, 3'd3);
        tick();
        checkOutput("coll_pending_end", bus.pending, 8'h00);
        waitDrain(5);
        applyStimulus(1'b0, 8'h00, 1'b0);
        doReset();

        // Reset asserted mid-grant, between clock edges.
        applyStimulus(1'b0, 8'h41, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0);
        tick();
        checkOutput("mid_w", bus.w, 3'd6);
        checkOutput("mid_pending", bus.pending, 8'h41);
        checkOutput("mid_valid", bus.valid, 1'b1);
        rst_n = 1'b0;
        #2;
        checkOutput("async_valid", bus.valid, 1'b0);
        checkOutput("async_w", bus.w, 3'd0);
        checkOutput("async_pending", bus.pending, 8'h00);
        checkOutput("async_multi", bus.multi, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("post_rst_valid", bus.valid, 1'b0);
        end
        exp_q.push_back(4);
        applyStimulus(1'b0, 8'h10, 1'b1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b1);
        waitDrain(10);
        checkOutput("post_rst_pending", bus.pending, 8'h00);
        applyStimulus(1'b0, 8'h00, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
